pwm_update_ctrl: RTL and testbench
==================================

# pwm_update_ctrl

Timebase sequencing controller for the PWM timer. It owns the prescaler's divide value and the counter enable. Software writes are buffered in a shadow register and transferred to `pwm_prescaler` only on a qualified update event (UEV). It also implements one-pulse mode and, optionally, a repetition counter that decimates update events.

## Interface
- `PSC_WIDTH`, 16, width of the prescaler divide value.
- `RCR_WIDTH`, 8, width of the repetition counter.
- `clk_psc_i`  in  1  timer kernel clock, shared with `pwm_prescaler`.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `cen_sw_i`  in  1  software counter enable (level).
- `opm_i`  in  1  one-pulse mode: stop counting after the first UEV.
- `udis_i`  in  1  update disable: blocks overflow-generated UEV.
- `ug_i`  in  1  software update generation (1-cycle pulse).
- `ovf_i`  in  1  counter overflow pulse from the main counter.
- `psc_wr_i`  in  1  write strobe for the PSC shadow.
- `psc_wdata_i`  in  PSC_WIDTH  PSC write data.
- `rcr_wr_i`  in  1  write strobe for the RCR shadow (only with the macro).
- `rcr_wdata_i`  in  RCR_WIDTH  RCR write data (only with the macro).
- `uif_clr_i`  in  1  clears `uif_o`.
- `psc_preload_o`  out  PSC_WIDTH  active divide value, driven to `pwm_prescaler.psc_preload_i`.
- `cen_o`  out  1  counter enable, driven to `pwm_prescaler.cen_i` and to the counter.
- `uev_o`  out  1  update event, 1-cycle pulse.
- `uif_o`  out  1  sticky update interrupt flag.
- `pending_o`  out  1  a shadow value is waiting for transfer.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `cen_sw_i` = 1.
  - RUN → IDLE when `cen_sw_i` = 0.
  - RUN → DONE on UEV while `opm_i` = 1.
  - DONE → IDLE when `cen_sw_i` = 0.
- `cen_o` is 1 only in RUN. In DONE the counter stays stopped until software drops and then re-asserts `cen_sw_i`.
- Qualified update event (raw):
  - `ug_i` = 1, in any state and regardless of `udis_i`; or
  - `ovf_i` & `cen_o` & ~`udis_i` & (rep_cnt == 0).
- `ovf_i` while `cen_o` = 0 is ignored.
- Effects of a raw UEV:
  - shadow PSC → `psc_preload_o`; `pending_o` cleared.
  - rep_cnt reloaded from the RCR shadow.
  - `uif_o` set.
- `ovf_i` & `cen_o` with rep_cnt ≠ 0 decrements rep_cnt and produces no UEV. This holds even when `udis_i` = 1.
- A `psc_wr_i` write loads the shadow and sets `pending_o`. `psc_preload_o` does not change until a UEV.
- Simultaneous `psc_wr_i` and raw UEV: the write data goes directly to `psc_preload_o` and `pending_o` stays 0.
- Simultaneous `uif_clr_i` and UEV: set wins.
- PSC arithmetic is unsigned. `psc_preload_o` = 0 means bypass (divide by 1), per the prescaler's contract.

## Timing
- All outputs are registered.
- Reset values: `psc_preload_o` = 0, `cen_o` = 0, `uev_o` = 0, `uif_o` = 0, `pending_o` = 0, shadow = 0, rep_cnt = 0, state IDLE.
- `uev_o`, the new `psc_preload_o`, `uif_o` and rep_cnt reload all appear on the edge after the raw event (1-cycle latency).
- `cen_o` rises one cycle after `cen_sw_i` rises.
- In OPM, `cen_o` falls on the same edge that `uev_o` asserts.
- Back-to-back `ug_i` pulses give back-to-back `uev_o` pulses.
- Reset asserted mid-run: all state returns to reset values on that edge. No UEV is emitted and the shadow contents are lost.

## Configuration
- `PWM_RCR_EN` defined:
  - RCR shadow and rep_cnt (RCR_WIDTH bits) are present, with `rcr_wr_i`/`rcr_wdata_i`.
  - An RCR write takes effect at the next UEV.
  - RCR = N gives one overflow-UEV per N+1 overflows.
- Not defined:
  - the RCR ports still exist but are ignored, and rep_cnt is constant 0.
  - every qualified overflow is a UEV.

## Structure
- Shared package `pwm_pkg`: FSM state enum (IDLE/RUN/DONE), default widths `PSC_WIDTH_DEF` = 16 and `RCR_WIDTH_DEF` = 8.
- One sub-module: `pwm_shadow_reg`, a parameterised width shadow + active register pair with write/transfer/pass-through logic and pending flag. It is instantiated for PSC, and for RCR under the macro.
- The FSM and UEV qualification live in the top.

## Test plan
- Reset: hold `rst_n_i` = 0 for 3 cycles with `psc_wr_i` = 1, data 7 → all outputs 0; after release `pending_o` = 0 and `psc_preload_o` = 0.
- Preload: write PSC = 4 in RUN → `pending_o` = 1 and `psc_preload_o` stays 0 until `ovf_i` pulses; one cycle after `ovf_i`, `psc_preload_o` = 4, `uev_o` = 1 for one cycle, `uif_o` = 1, `pending_o` = 0.
- UDIS/UG: `udis_i` = 1, PSC write 10, `ovf_i` ×3 → no `uev_o` and `psc_preload_o` unchanged; then `ug_i` → `psc_preload_o` = 10 and `uev_o` pulses.
- One-pulse: `opm_i` = 1, `cen_sw_i` = 1, first `ovf_i` → `cen_o` drops with `uev_o`; further `ovf_i` is ignored; `cen_sw_i` 0→1 restarts with `cen_o` = 1 one cycle later.
- Collision: `psc_wr_i` with data 9 in the same cycle as a qualified `ovf_i` → `psc_preload_o` = 9 next cycle and `pending_o` = 0; `uif_clr_i` in the same cycle as UEV leaves `uif_o` = 1.
- With `PWM_RCR_EN`: RCR = 2, then `ug_i`, then 6 qualified `ovf_i` → `uev_o` on the 3rd and 6th only.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timebase blocks.
//   pwm_state_e   : update-controller FSM state (IDLE / RUN / DONE)
//   PSC_WIDTH_DEF : default prescaler divide-value width
//   RCR_WIDTH_DEF : default repetition-counter width
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pwm_state_e;

  localparam int unsigned PSC_WIDTH_DEF = 16;
  localparam int unsigned RCR_WIDTH_DEF = 8;

endpackage

// File: rtl/pwm_shadow_reg.sv
// Shadow + active register pair.
// A write loads the shadow and marks it pending. A transfer copies the shadow
// into the active register and clears pending. A write coinciding with a
// transfer passes the write data straight to the active register.
//   clk_i      : clock
//   rst_n_i    : synchronous active-low reset
//   wr_i       : shadow write strobe
//   wdata_i    : shadow write data
//   xfer_i     : transfer strobe (update event)
//   active_o   : active (in-use) value
//   xfer_val_o : value an xfer in this cycle loads (write data or shadow)
//   pending_o  : shadow holds a value not yet transferred
module pwm_shadow_reg #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         wr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         xfer_i,
  output logic [W-1:0] active_o,
  output logic [W-1:0] xfer_val_o,
  output logic         pending_o
);

  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] active_q, active_d;
  logic         pending_q, pending_d;

  assign xfer_val_o = wr_i ? wdata_i : shadow_q;

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (wr_i) begin
      shadow_d  = wdata_i;
      pending_d = 1'b1;
    end
    if (xfer_i) begin
      active_d  = xfer_val_o;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign active_o  = active_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/pwm_update_ctrl.sv
// Timebase sequencing controller for the PWM timer.
// Owns the prescaler divide value (shadowed, transferred on update event) and
// the counter enable; implements one-pulse mode and, when PWM_RCR_EN is
// defined, a repetition counter decimating overflow update events.
//   clk_psc_i     : timer kernel clock
//   rst_n_i       : synchronous active-low reset
//   cen_sw_i      : software counter enable (level)
//   opm_i         : one-pulse mode
//   udis_i        : blocks overflow-generated update events
//   ug_i          : software update generation pulse
//   ovf_i         : counter overflow pulse
//   psc_wr_i/psc_wdata_i : PSC shadow write
//   rcr_wr_i/rcr_wdata_i : RCR shadow write (used only with PWM_RCR_EN)
//   uif_clr_i     : clears uif_o
//   psc_preload_o : active prescaler divide value
//   cen_o         : counter enable
//   uev_o         : update event pulse
//   uif_o         : sticky update flag
//   pending_o     : PSC shadow awaiting transfer
module pwm_update_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned PSC_WIDTH = PSC_WIDTH_DEF,
  parameter int unsigned RCR_WIDTH = RCR_WIDTH_DEF
) (
  input  logic                 clk_psc_i,
  input  logic                 rst_n_i,
  input  logic                 cen_sw_i,
  input  logic                 opm_i,
  input  logic                 udis_i,
  input  logic                 ug_i,
  input  logic                 ovf_i,
  input  logic                 psc_wr_i,
  input  logic [PSC_WIDTH-1:0] psc_wdata_i,
  input  logic                 rcr_wr_i,
  input  logic [RCR_WIDTH-1:0] rcr_wdata_i,
  input  logic                 uif_clr_i,
  output logic [PSC_WIDTH-1:0] psc_preload_o,
  output logic                 cen_o,
  output logic                 uev_o,
  output logic                 uif_o,
  output logic                 pending_o
);

  pwm_state_e state_q, state_d;
  logic       cen_q, cen_d;
  logic       uev_q;
  logic       uif_q, uif_d;
  logic       uev_raw;
  logic       ovf_qual;
  logic       rep_zero;

  logic [PSC_WIDTH-1:0] unused_psc_xfer_val;

  // Overflows are only meaningful while the counter is enabled.
  assign ovf_qual = ovf_i & cen_q;
  assign uev_raw  = ug_i | (ovf_qual & ~udis_i & rep_zero);

  pwm_shadow_reg #(.W(PSC_WIDTH)) u_psc_shadow (
    .clk_i      (clk_psc_i),
    .rst_n_i    (rst_n_i),
    .wr_i       (psc_wr_i),
    .wdata_i    (psc_wdata_i),
    .xfer_i     (uev_raw),
    .active_o   (psc_preload_o),
    .xfer_val_o (unused_psc_xfer_val),
    .pending_o  (pending_o)
  );

`ifdef PWM_RCR_EN
  logic [RCR_WIDTH-1:0] rep_cnt_q, rep_cnt_d;
  logic [RCR_WIDTH-1:0] rcr_reload;
  logic [RCR_WIDTH-1:0] unused_rcr_active;
  logic                 unused_rcr_pending;

  pwm_shadow_reg #(.W(RCR_WIDTH)) u_rcr_shadow (
    .clk_i      (clk_psc_i),
    .rst_n_i    (rst_n_i),
    .wr_i       (rcr_wr_i),
    .wdata_i    (rcr_wdata_i),
    .xfer_i     (uev_raw),
    .active_o   (unused_rcr_active),
    .xfer_val_o (rcr_reload),
    .pending_o  (unused_rcr_pending)
  );

  assign rep_zero = (rep_cnt_q == '0);

  // Decrement on qualified overflow even when udis_i blocks the update.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    if (uev_raw)
      rep_cnt_d = rcr_reload;
    else if (ovf_qual && !rep_zero)
      rep_cnt_d = rep_cnt_q - 1'b1;
  end

  always_ff @(posedge clk_psc_i) begin
    if (!rst_n_i) rep_cnt_q <= '0;
    else          rep_cnt_q <= rep_cnt_d;
  end
`else
  logic unused_rcr;
  assign unused_rcr = ^{rcr_wr_i, rcr_wdata_i};
  assign rep_zero   = 1'b1;
`endif

  // FSM: state register
  always_ff @(posedge clk_psc_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cen_sw_i) state_d = RUN;
      RUN: begin
        if (!cen_sw_i)            state_d = IDLE;
        else if (uev_raw && opm_i) state_d = DONE;
      end
      DONE: if (!cen_sw_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. cen is decoded from the next state and registered so it
  // tracks RUN exactly while still being a flop output.
  always_comb begin
    cen_d = (state_d == RUN);
  end

  always_comb begin
    uif_d = uif_q;
    if (uif_clr_i) uif_d = 1'b0;
    if (uev_raw)   uif_d = 1'b1;
  end

  always_ff @(posedge clk_psc_i) begin
    if (!rst_n_i) begin
      cen_q <= 1'b0;
      uev_q <= 1'b0;
      uif_q <= 1'b0;
    end else begin
      cen_q <= cen_d;
      uev_q <= uev_raw;
      uif_q <= uif_d;
    end
  end

  assign cen_o = cen_q;
  assign uev_o = uev_q;
  assign uif_o = uif_q;

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// Directed self-checking bench for pwm_update_ctrl.
module tb_pwm_update_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cen_sw, opm, udis, ug, ovf, psc_wr, rcr_wr, uif_clr;
  logic [15:0] psc_wdata;
  logic [7:0]  rcr_wdata;
  logic [15:0] psc_preload;
  logic        cen, uev, uif, pending;

  int checks = 0;
  int errors = 0;

  pwm_update_ctrl #(.PSC_WIDTH(16), .RCR_WIDTH(8)) dut (
    .clk_psc_i     (clk),
    .rst_n_i       (rst_n),
    .cen_sw_i      (cen_sw),
    .opm_i         (opm),
    .udis_i        (udis),
    .ug_i          (ug),
    .ovf_i         (ovf),
    .psc_wr_i      (psc_wr),
    .psc_wdata_i   (psc_wdata),
    .rcr_wr_i      (rcr_wr),
    .rcr_wdata_i   (rcr_wdata),
    .uif_clr_i     (uif_clr),
    .psc_preload_o (psc_preload),
    .cen_o         (cen),
    .uev_o         (uev),
    .uif_o         (uif),
    .pending_o     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; cen_sw = 1'b0; opm = 1'b0; udis = 1'b0; ug = 1'b0; ovf = 1'b0;
    psc_wr = 1'b1; psc_wdata = 16'd7; rcr_wr = 1'b0; rcr_wdata = '0; uif_clr = 1'b0;

    // Reset held with a write pending on the bus
    repeat (3) tick();
    chk("rst_preload", psc_preload, 0);
    chk("rst_cen", cen, 0);
    chk("rst_uev", uev, 0);
    chk("rst_uif", uif, 0);
    chk("rst_pending", pending, 0);
    rst_n = 1'b1; psc_wr = 1'b0;
    tick();
    chk("post_rst_pending", pending, 0);
    chk("post_rst_preload", psc_preload, 0);

    // Start counter, buffered PSC write, transfer on overflow
    cen_sw = 1'b1;
    tick();
    chk("cen_rise", cen, 1);
    psc_wr = 1'b1; psc_wdata = 16'd4;
    tick();
    psc_wr = 1'b0;
    chk("pre_pending", pending, 1);
    chk("pre_hold", psc_preload, 0);
    tick();
    chk("pre_hold2", psc_preload, 0);
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    chk("ovf_preload", psc_preload, 4);
    chk("ovf_uev", uev, 1);
    chk("ovf_uif", uif, 1);
    chk("ovf_pending", pending, 0);
    tick();
    chk("uev_one_cycle", uev, 0);
    chk("uif_sticky", uif, 1);
    uif_clr = 1'b1;
    tick();
    uif_clr = 1'b0;
    chk("uif_clr", uif, 0);

    // Update disable blocks overflow UEVs but not UG
    udis = 1'b1; psc_wr = 1'b1; psc_wdata = 16'd10;
    tick();
    psc_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ovf = 1'b1;
      tick();
      ovf = 1'b0;
      chk("udis_no_uev", uev, 0);
      tick();
    end
    chk("udis_preload", psc_preload, 4);
    chk("udis_pending", pending, 1);
    ug = 1'b1;
    tick();
    ug = 1'b0;
    chk("ug_preload", psc_preload, 10);
    chk("ug_uev", uev, 1);
    tick();
    chk("ug_uev_end", uev, 0);
    udis = 1'b0;

    // Back-to-back UG
    ug = 1'b1;
    tick();
    chk("b2b_uev1", uev, 1);
    tick();
    ug = 1'b0;
    chk("b2b_uev2", uev, 1);
    tick();
    chk("b2b_uev_end", uev, 0);

    // Write colliding with qualified overflow, clear colliding with set
    psc_wr = 1'b1; psc_wdata = 16'd9; ovf = 1'b1; uif_clr = 1'b1;
    tick();
    psc_wr = 1'b0; ovf = 1'b0; uif_clr = 1'b0;
    chk("coll_preload", psc_preload, 9);
    chk("coll_pending", pending, 0);
    chk("coll_uif", uif, 1);
    chk("coll_uev", uev, 1);

    // Overflow ignored while stopped
    cen_sw = 1'b0;
    tick();
    chk("stop_cen", cen, 0);
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    chk("stopped_ovf_uev", uev, 0);

    // One-pulse mode
    opm = 1'b1; cen_sw = 1'b1;
    tick();
    chk("opm_cen", cen, 1);
    ovf = 1'b1;
    tick();
    chk("opm_cen_drop", cen, 0);
    chk("opm_uev", uev, 1);
    tick();
    ovf = 1'b0;
    chk("opm_ovf_ignored", uev, 0);
    chk("opm_done_cen", cen, 0);
    cen_sw = 1'b0;
    tick();
    chk("opm_idle_cen", cen, 0);
    cen_sw = 1'b1;
    tick();
    chk("opm_restart_cen", cen, 1);
    opm = 1'b0;

    // Mid-run reset discards shadow and emits no UEV
    psc_wr = 1'b1; psc_wdata = 16'd3;
    tick();
    psc_wr = 1'b0;
    chk("mid_pending", pending, 1);
    rst_n = 1'b0; ovf = 1'b1;
    tick();
    rst_n = 1'b1; ovf = 1'b0;
    chk("mid_rst_preload", psc_preload, 0);
    chk("mid_rst_uev", uev, 0);
    chk("mid_rst_cen", cen, 0);
    chk("mid_rst_pending", pending, 0);
    ug = 1'b1;
    tick();
    ug = 1'b0;
    chk("mid_rst_shadow_lost", psc_preload, 0);

`ifdef PWM_RCR_EN
    // Repetition counter: RCR=2 gives a UEV every third overflow
    cen_sw = 1'b1;
    tick();
    rcr_wr = 1'b1; rcr_wdata = 8'd2;
    tick();
    rcr_wr = 1'b0;
    ug = 1'b1;
    tick();
    ug = 1'b0;
    chk("rcr_ug_uev", uev, 1);
    for (int i = 1; i <= 6; i++) begin
      ovf = 1'b1;
      tick();
      ovf = 1'b0;
      chk($sformatf("rcr_ovf%0d", i), uev, ((i == 3) || (i == 6)) ? 1 : 0);
      tick();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
